mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core. Sits beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles.
- Drives `busy` so the hazard unit can stall MFHI/MFLO and any new MDU op while a computation is in flight.

---
 rtl/mdu_iter.sv | 205 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
//
// It sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU and runs a
// radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop over
// WIDTH cycles. A FIX cycle then applies sign correction and writes HI/LO.
// MTHI/MTLO write HI/LO directly from operand a in a single cycle.
//
// Optional build macro: MDU_EARLY_OUT_EN. When defined, an accepted MULT/DIV
// with a zero operand skips the iteration loop and goes straight to FIX.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        op request, sampled in IDLE
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                11x reserved (ignored)
//   a, b         rs / rt operands (already forwarded)
//   flush        aborts an in-flight op; also blocks acceptance in IDLE
//   busy         high while an op is iterating or being finalised
//   done         one-cycle pulse when MULT/DIV results land in HI/LO
//   div_by_zero  one-cycle pulse alongside done for a divide with b == 0
//   hi, lo       HI / LO registers
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Magnitude of a W-bit value, treating it as two's complement when sgn=1.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x,
                                             input logic sgn);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    if (sgn && (xs < 0)) return -xs;
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x,
                                             input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x,
                                                input logic en);
    return en ? -x : x;
  endfunction

  state_t state, state_nx;

  logic             is_md, is_mt, op_sgn;
  logic             accept, mt_wr, step, commit;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Latched operation context.
  logic                 is_div_r;
  logic                 neg_r;     // negate product / quotient
  logic                 rneg_r;    // negate remainder (dividend was negative)
  logic                 dz_r;      // divisor was zero
  logic [WIDTH-1:0]     a_r;       // original dividend, returned in HI on /0
  logic [CNT_W-1:0]     cnt;
  // Multiply: acc_r = running product, mc_r = shifted multiplicand,
  // mp_r = remaining multiplier bits.
  // Divide: acc_r = {remainder, dividend/quotient}, mc_r[WIDTH-1:0] = divisor.
  logic [2*WIDTH-1:0]   acc_r, mc_r;
  logic [WIDTH-1:0]     mp_r;

  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_diff;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     res_hi, res_lo;

  assign is_md  = ~op[2];
  assign is_mt  = (op[2:1] == 2'b10);
  assign op_sgn = ~op[0];
  assign a_mag  = abs_w(a, op_sgn);
  assign b_mag  = abs_w(b, op_sgn);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start && !flush && is_md) begin
`ifdef MDU_EARLY_OUT_EN
          state_nx = ((a == '0) || (b == '0)) ? S_FIX : S_CALC;
`else
          state_nx = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush)                state_nx = S_IDLE;
        else if (cnt == LAST_CNT) state_nx = S_FIX;
      end
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output / control strobes
  always_comb begin
    busy   = (state == S_CALC) || (state == S_FIX);
    accept = (state == S_IDLE) && start && !flush && is_md;
    mt_wr  = (state == S_IDLE) && start && !flush && is_mt;
    step   = (state == S_CALC) && !flush;
    commit = (state == S_FIX) && !flush;
  end

  // Restoring-divide step: shift one dividend bit into the partial remainder
  // and subtract the divisor if it fits. Since remainder < divisor, the
  // difference always fits in WIDTH bits when the subtraction is taken.
  always_comb begin
    rem_sh   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, mc_r[WIDTH-1:0]});
    rem_diff = rem_sh[WIDTH-1:0] - mc_r[WIDTH-1:0];
  end

  // Final sign correction and result selection
  always_comb begin
    prod_fix = neg_2w(acc_r, neg_r);
    if (!is_div_r) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (dz_r) begin
      res_hi = a_r;
      res_lo = '1;
    end else begin
      res_hi = neg_w(acc_r[2*WIDTH-1:WIDTH], rneg_r);
      res_lo = neg_w(acc_r[WIDTH-1:0], neg_r);
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      is_div_r    <= 1'b0;
      neg_r       <= 1'b0;
      rneg_r      <= 1'b0;
      dz_r        <= 1'b0;
      a_r         <= '0;
      cnt         <= '0;
      acc_r       <= '0;
      mc_r        <= '0;
      mp_r        <= '0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= commit;
      div_by_zero <= commit && is_div_r && dz_r;
      if (accept) begin
        is_div_r <= op[1];
        neg_r    <= op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_r   <= op_sgn && a[WIDTH-1];
        dz_r     <= (b == '0);
        a_r      <= a;
        cnt      <= '0;
        acc_r    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
        mc_r     <= op[1] ? {{WIDTH{1'b0}}, b_mag} : {{WIDTH{1'b0}}, a_mag};
        mp_r     <= b_mag;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
        if (is_div_r) begin
          acc_r <= {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]),
                    acc_r[WIDTH-2:0], rem_ge};
        end else begin
          acc_r <= acc_r + (mp_r[0] ? mc_r : '0);
          mc_r  <= mc_r << 1;
          mp_r  <= mp_r >> 1;
        end
      end
      if (mt_wr && !op[0]) hi <= a;
      if (mt_wr &&  op[0]) lo <= a;
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  localparam int W = 32;

  logic          clk, rst, start, flush;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: results straight from integer arithmetic on the operands.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x,
                                input logic [W-1:0] y, output logic [W-1:0] rh,
                                output logic [W-1:0] rl, output logic rz);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rz = 1'b0;
    p  = '0;
    case (o)
      3'd0: p = sx * sy;
      3'd1: p = 64'(x) * 64'(y);
      3'd2: if (y != 0) p = {32'(sx % sy), 32'(sx / sy)};
      default: if (y != 0) p = {x % y, x / y};
    endcase
    rh = p[63:32];
    rl = p[31:0];
    if (o[1] && y == 0) begin
      rh = x;
      rl = '1;
      rz = 1'b1;
    end
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] rh, rl;
    logic rz;
    int n, bcnt, lat;
    model(o, x, y, rh, rl, rz);
    lat = W + 1;
`ifdef MDU_EARLY_OUT_EN
    if (x == 0 || y == 0) lat = 1;
`endif
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;
    bcnt = busy ? 1 : 0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'(lat));
    chk({tag, " hi"}, 64'(hi), 64'(rh));
    chk({tag, " lo"}, 64'(lo), 64'(rl));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(rz));
    tick();
    chk({tag, " done_pulse"}, 64'(done), 64'(0));
    exp_hi = rh;
    exp_lo = rl;
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra, rb;
    logic [2:0] ro;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    tick();
    tick();
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset dbz", 64'(div_by_zero), 64'(0));
    rst = 1'b0;
    tick();

    run_op("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'd7);
    chk("mult_neg3x7 hi const", 64'(exp_hi), 64'h0FFFFFFFF);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2);
    run_op("divu_7_2", 3'd3, 32'd7, 32'd2);
    run_op("div_by_zero", 3'd2, 32'd5, 32'd0);
    run_op("divu_by_zero", 3'd3, 32'hDEADBEEF, 32'd0);
    run_op("div_minneg_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op("mult_zero", 3'd0, 32'd0, 32'h12345678);
    run_op("div_neg_divisor", 3'd2, 32'd100, 32'hFFFFFFF9);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        2: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    // Reserved op does nothing.
    op = 3'd6; a = 32'h55AA55AA; start = 1'b1;
    tick();
    start = 1'b0;
    chk("reserved busy", 64'(busy), 64'(0));
    chk("reserved hi", 64'(hi), 64'(exp_hi));
    chk("reserved lo", 64'(lo), 64'(exp_lo));

    // flush and start together in IDLE: nothing accepted.
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start busy", 64'(busy), 64'(0));

    // MTHI, then MULT 6*7 with an ignored DIVU at edge 5 and flush at edge 10.
    op = 3'd4; a = 32'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo", 64'(lo), 64'(exp_lo));
    chk("mthi busy", 64'(busy), 64'(0));
    chk("mthi done", 64'(done), 64'(0));
    exp_hi = 32'h1234;
    op = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
    tick();                                  // edge 0
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    op = 3'd3; a = 32'd100; b = 32'd3; start = 1'b1;
    tick();                                  // edge 5
    start = 1'b0;
    chk("start_while_busy busy", 64'(busy), 64'(1));
    for (int e = 6; e <= 9; e++) tick();
    flush = 1'b1;
    tick();                                  // edge 10
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'(0));
    chk("flush done", 64'(done), 64'(0));
    chk("flush hi", 64'(hi), 64'h1234);
    chk("flush lo", 64'(lo), 64'(exp_lo));
    ndone = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("flush no_late_done", 64'(ndone), 64'(0));
    chk("flush hi later", 64'(hi), 64'h1234);

    // Clean op after the abort.
    run_op("after_flush", 3'd0, 32'd6, 32'd7);

    // Async reset mid-operation.
    op = 3'd1; a = 32'hFFFF0000; b = 32'h00FF00FF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    rst = 1'b1;
    #2;
    chk("async_rst hi", 64'(hi), 64'(0));
    chk("async_rst lo", 64'(lo), 64'(0));
    chk("async_rst busy", 64'(busy), 64'(0));
    chk("async_rst done", 64'(done), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    op = 3'd5; a = 32'hCAFE; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mtlo lo", 64'(lo), 64'hCAFE);
    chk("mtlo hi", 64'(hi), 64'(0));
    chk("mtlo busy", 64'(busy), 64'(0));
    ndone = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done) ndone++;
    end
    chk("rst no_done", 64'(ndone), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
